// File: rtl/fix_pkg.sv
// Shared FIX session definitions: message type codes and scheduler state encoding.
// create_message imports the same message type constants.
package fix_pkg;

  typedef logic [2:0] msg_type_t;

  localparam msg_type_t MSG_NONE  = 3'b000;
  localparam msg_type_t LOGON     = 3'b001;
  localparam msg_type_t HEARTBEAT = 3'b010;
  localparam msg_type_t LOGOUT    = 3'b100;
  localparam msg_type_t BUSINESS  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACTIVE,
    S_CLOSED
  } sched_state_t;

endpackage

// File: rtl/fix_hb_timer.sv
// Saturating heartbeat interval counter with clear, enable and a due flag.
// The clear cycle counts as the first elapsed cycle, so a heartbeat starts interval+1 cycles after done.
module fix_hb_timer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic [CNT_WIDTH-1:0] i_interval,
  output logic                 o_due
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_base;
  logic [CNT_WIDTH-1:0] w_next;

  always_comb begin
    w_base = i_clr ? '0 : r_cnt;
    if (w_base >= i_interval) begin
      w_next = i_interval;
    end else begin
      w_next = w_base + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_next;
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

  assign o_due = (i_interval != '0) && (r_cnt >= i_interval);

endmodule

// File: rtl/fix_session_scheduler.sv
// FIX session controller: picks logon/heartbeat/business/logout, pulses create_message start,
// and owns MsgSeqNum, the heartbeat timer and the completion watchdog.
module fix_session_scheduler
  import fix_pkg::*;
#(
  parameter int SEQ_WIDTH    = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] hb_interval_i,
  input  logic                 biz_req_i,
  output logic                 biz_ack_o,
  output logic                 start_o,
  output logic [2:0]           message_type_o,
  output logic [SEQ_WIDTH-1:0] msg_seq_num_o,
  input  logic                 msg_creation_done_i,
  output logic                 session_active_o,
  output logic                 busy_o,
  output logic                 error_o
);

  localparam int                   WD_WIDTH  = $clog2(DONE_TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0]  WD_LAST   = WD_WIDTH'(DONE_TIMEOUT - 1);
  localparam logic [SEQ_WIDTH-1:0] SEQ_FIRST = SEQ_WIDTH'(1);

  sched_state_t         r_state;
  sched_state_t         w_state_nxt;
  msg_type_t            r_type;
  msg_type_t            w_type_nxt;
  logic [SEQ_WIDTH-1:0] r_seq;
  logic [SEQ_WIDTH-1:0] w_seq_nxt;
  logic [WD_WIDTH-1:0]  r_wd;
  logic [WD_WIDTH-1:0]  w_wd_nxt;
  logic                 r_start;
  logic                 r_ack;
  logic                 r_busy;
  logic                 r_active;
  logic                 w_active_nxt;
  logic                 r_error;
  logic                 w_error_nxt;
  logic                 w_hb_en;
  logic                 w_hb_clr;
  logic                 w_hb_due;

  assign w_hb_en = (r_state != S_IDLE) && (r_state != S_CLOSED);

  fix_hb_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_hb_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_hb_en),
    .i_clr      (w_hb_clr),
    .i_interval (hb_interval_i),
    .o_due      (w_hb_due)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_type_nxt   = r_type;
    w_seq_nxt    = r_seq;
    w_wd_nxt     = r_wd;
    w_active_nxt = r_active;
    w_error_nxt  = r_error;
    w_hb_clr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i) begin
          w_type_nxt  = LOGON;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_wd_nxt    = WD_WIDTH'(1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (msg_creation_done_i) begin
          w_seq_nxt = (r_seq == '1) ? SEQ_FIRST : r_seq + SEQ_WIDTH'(1);
          w_hb_clr  = 1'b1;
          if (r_type == LOGOUT) begin
            w_active_nxt = 1'b0;
            w_state_nxt  = S_CLOSED;
          end else begin
            if (r_type == LOGON) w_active_nxt = 1'b1;
            w_state_nxt = S_ACTIVE;
          end
        end else if (r_wd >= WD_LAST) begin
          // Watchdog expiry: the message is abandoned and MsgSeqNum is not consumed.
          w_error_nxt  = 1'b1;
          w_active_nxt = 1'b0;
          w_state_nxt  = S_CLOSED;
        end else begin
          w_wd_nxt = r_wd + WD_WIDTH'(1);
        end
      end
      S_ACTIVE: begin
        if (!enable_i) begin
          w_type_nxt  = LOGOUT;
          w_state_nxt = S_START;
        end else if (biz_req_i) begin
          w_type_nxt  = BUSINESS;
          w_state_nxt = S_START;
        end else if (w_hb_due) begin
          w_type_nxt  = HEARTBEAT;
          w_state_nxt = S_START;
        end
      end
      S_CLOSED: begin
        if (!enable_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; outputs are registered from next-state decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_type   <= MSG_NONE;
      r_seq    <= SEQ_FIRST;
      r_wd     <= '0;
      r_start  <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_active <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_type   <= w_type_nxt;
      r_seq    <= w_seq_nxt;
      r_wd     <= w_wd_nxt;
      r_start  <= (w_state_nxt == S_START);
      r_ack    <= (w_state_nxt == S_START) && (w_type_nxt == BUSINESS);
      r_busy   <= (w_state_nxt == S_START) || (w_state_nxt == S_WAIT);
      r_active <= w_active_nxt;
      r_error  <= w_error_nxt;
    end
  end

  assign start_o          = r_start;
  assign biz_ack_o        = r_ack;
  assign busy_o           = r_busy;
  assign session_active_o = r_active;
  assign error_o          = r_error;
  assign message_type_o   = r_type;
  assign msg_seq_num_o    = r_seq;

endmodule

// File: tb/tb_fix_session_scheduler.sv
// Self-checking bench for fix_session_scheduler: randomized stimulus against a session-level
// reference model that predicts each cycle from elapsed-cycle arithmetic and the session rules.
module tb_fix_session_scheduler;
  import fix_pkg::*;

  localparam int SW = 4;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_i;
  logic [CW-1:0] hb_interval_i;
  logic          biz_req_i;
  logic          done_i;
  logic          biz_ack_o;
  logic          start_o;
  logic [2:0]    message_type_o;
  logic [SW-1:0] msg_seq_num_o;
  logic          session_active_o;
  logic          busy_o;
  logic          error_o;

  fix_session_scheduler #(
    .SEQ_WIDTH    (SW),
    .CNT_WIDTH    (CW),
    .DONE_TIMEOUT (TO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_i            (enable_i),
    .hb_interval_i       (hb_interval_i),
    .biz_req_i           (biz_req_i),
    .biz_ack_o           (biz_ack_o),
    .start_o             (start_o),
    .message_type_o      (message_type_o),
    .msg_seq_num_o       (msg_seq_num_o),
    .msg_creation_done_i (done_i),
    .session_active_o    (session_active_o),
    .busy_o              (busy_o),
    .error_o             (error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_ack = 0;
  int last_start = -1;
  int done_at = -1;
  int lat_lo = 5;
  int lat_hi = 5;
  bit withhold = 1'b0;
  bit stray = 1'b0;
  bit force_done = 1'b0;
  int hb_q[$];
  int hbseq_q[$];

  // Reference model of the session as seen from outside.
  bit        m_start, m_ack, m_busy, m_active, m_closed, m_err;
  int        m_seq, m_st_cyc, m_last_done;
  logic [2:0] m_type;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic launch(input logic [2:0] t);
    m_busy   = 1'b1;
    m_st_cyc = cyc + 1;
    m_type   = t;
    m_start  = 1'b1;
    m_ack    = (t == BUSINESS);
  endtask

  // Decides what the session looks like in cycle cyc+1 given the inputs of cycle cyc.
  task automatic model_advance();
    m_start = 1'b0;
    m_ack   = 1'b0;
    if (rst !== 1'b1) begin
      m_busy = 1'b0; m_active = 1'b0; m_closed = 1'b0; m_err = 1'b0;
      m_seq = 1; m_type = 3'b000; m_last_done = 0; m_st_cyc = 0;
    end else if (m_busy) begin
      if (done_i && cyc != m_st_cyc) begin
        m_seq = (m_seq + 1) % (1 << SW);
        if (m_seq == 0) m_seq = 1;
        m_last_done = cyc;
        m_busy = 1'b0;
        if (m_type == LOGON) m_active = 1'b1;
        else if (m_type == LOGOUT) begin
          m_active = 1'b0;
          m_closed = 1'b1;
        end
      end else if (cyc - m_st_cyc == TO - 1) begin
        m_err = 1'b1; m_active = 1'b0; m_closed = 1'b1; m_busy = 1'b0;
      end
    end else if (m_closed) begin
      if (!enable_i) m_closed = 1'b0;
    end else if (!m_active) begin
      if (enable_i) launch(LOGON);
    end else if (!enable_i) launch(LOGOUT);
    else if (biz_req_i) launch(BUSINESS);
    else if (hb_interval_i != '0 && cyc - m_last_done >= int'(hb_interval_i)) launch(HEARTBEAT);
  endtask

  task automatic step();
    done_i = force_done || (!withhold && cyc == done_at) || (stray && $urandom_range(0, 39) == 0);
    model_advance();
    @(negedge clk);
    cyc++;
    if (start_o === 1'b1) begin
      n_start++;
      last_start = cyc;
      if (message_type_o == HEARTBEAT) begin
        hb_q.push_back(cyc);
        hbseq_q.push_back(int'(msg_seq_num_o));
      end
      done_at = cyc + int'($urandom_range(32'(lat_lo), 32'(lat_hi)));
    end
    if (biz_ack_o === 1'b1) n_ack++;
    check("start_o", 32'(start_o), 32'(m_start));
    check("biz_ack_o", 32'(biz_ack_o), 32'(m_ack));
    check("busy_o", 32'(busy_o), 32'(m_busy));
    check("session_active_o", 32'(session_active_o), 32'(m_active));
    check("error_o", 32'(error_o), 32'(m_err));
    check("message_type_o", 32'(message_type_o), 32'(m_type));
    check("msg_seq_num_o", 32'(msg_seq_num_o), m_seq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0, s0, seq0, ns0, hbn;
    rst = 1'b0; enable_i = 1'b0; biz_req_i = 1'b0; done_i = 1'b0; hb_interval_i = '0;
    m_busy = 0; m_active = 0; m_closed = 0; m_err = 0; m_seq = 1; m_type = 3'b000;
    m_last_done = 0; m_st_cyc = 0;
    repeat (3) step();
    check("rst_seq", 32'(msg_seq_num_o), 1);
    check("rst_type", 32'(message_type_o), 0);
    check("rst_flags", 32'({start_o, biz_ack_o, busy_o, session_active_o, error_o}), 0);

    // Logon with done 5 cycles after start.
    rst = 1'b1; hb_interval_i = CW'(100);
    repeat (2) step();
    enable_i = 1'b1; e0 = cyc; ns0 = n_start;
    for (int k = 0; k < 10 && n_start == ns0; k++) step();
    check("t1_start_latency", last_start - e0, 1);
    check("t1_type", 32'(message_type_o), 32'(LOGON));
    check("t1_seq", 32'(msg_seq_num_o), 1);
    for (int k = 0; k < 40 && session_active_o !== 1'b1; k++) step();
    check("t1_active", 32'(session_active_o), 1);
    check("t1_seq_after", 32'(msg_seq_num_o), 2);

    // Idle session: heartbeats every 100+1+5 cycles.
    hb_q.delete(); hbseq_q.delete();
    for (int k = 0; k < 600 && hb_q.size() < 3; k++) step();
    check("t2_hb_count", 32'(hb_q.size() >= 3), 1);
    if (hb_q.size() >= 3) begin
      check("t2_gap1", hb_q[1] - hb_q[0], 106);
      check("t2_gap2", hb_q[2] - hb_q[1], 106);
      check("t2_seq0", hbseq_q[0], 2);
      check("t2_seq1", hbseq_q[1], 3);
      check("t2_seq2", hbseq_q[2], 4);
    end

    // Three business messages, then the heartbeat comes 51 cycles after the last done.
    hb_interval_i = CW'(50); lat_lo = 10; lat_hi = 10; n_ack = 0; biz_req_i = 1'b1;
    for (int k = 0; k < 300 && n_ack < 3; k++) step();
    biz_req_i = 1'b0;
    hbn = hb_q.size();
    for (int k = 0; k < 300 && hb_q.size() == hbn; k++) step();
    check("t3_acks", n_ack, 3);
    check("t3_hb_seen", 32'(hb_q.size() > hbn), 1);
    if (hb_q.size() > hbn) check("t3_hb_gap", hb_q[$] - m_last_done, 51);

    // Random business traffic with random done latency and stray dones.
    lat_lo = 1; lat_hi = 12; stray = 1'b1;
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) biz_req_i = ~biz_req_i;
      step();
    end

    // enable_i and biz_req_i fall together in an active cycle: logout, no ack.
    stray = 1'b0; biz_req_i = 1'b1;
    for (int k = 0; k < 100 && busy_o !== 1'b1; k++) step();
    for (int k = 0; k < 100 && busy_o === 1'b1; k++) step();
    enable_i = 1'b0; biz_req_i = 1'b0;
    step();
    check("t4_logout_start", 32'(start_o), 1);
    check("t4_logout_type", 32'(message_type_o), 32'(LOGOUT));
    check("t4_no_ack", 32'(biz_ack_o), 0);
    for (int k = 0; k < 40 && (busy_o === 1'b1 || session_active_o === 1'b1); k++) step();
    check("t4_inactive", 32'(session_active_o), 0);
    ns0 = n_start;
    repeat (30) step();
    check("t4_no_starts", n_start - ns0, 0);

    // Watchdog: done withheld, error 16 cycles after start, stray done afterwards ignored.
    enable_i = 1'b1; lat_lo = 4; lat_hi = 4;
    for (int k = 0; k < 60 && session_active_o !== 1'b1; k++) step();
    withhold = 1'b1; biz_req_i = 1'b1; ns0 = n_start;
    for (int k = 0; k < 20 && n_start == ns0; k++) step();
    biz_req_i = 1'b0; s0 = last_start; seq0 = int'(msg_seq_num_o);
    for (int k = 0; k < 40 && error_o !== 1'b1; k++) step();
    check("t5_err_delay", cyc - s0, 16);
    check("t5_seq_kept", 32'(msg_seq_num_o), seq0);
    force_done = 1'b1; step(); force_done = 1'b0;
    ns0 = n_start;
    repeat (4) step();
    check("t5_stray_seq", 32'(msg_seq_num_o), seq0);
    check("t5_no_starts", n_start - ns0, 0);
    enable_i = 1'b0; repeat (3) step();
    withhold = 1'b0;

    // Reset while waiting for done on the seq=7 message.
    rst = 1'b0; step(); rst = 1'b1; step();
    enable_i = 1'b1; biz_req_i = 1'b1; lat_lo = 2; lat_hi = 6;
    for (int k = 0; k < 300 && !(start_o === 1'b1 && msg_seq_num_o == SW'(7)); k++) step();
    withhold = 1'b1; biz_req_i = 1'b0;
    repeat (2) step();
    check("t6_in_wait", 32'({busy_o, msg_seq_num_o}), 32'({1'b1, SW'(7)}));
    rst = 1'b0; enable_i = 1'b0; step(); rst = 1'b1;
    check("t6_rst_seq", 32'(msg_seq_num_o), 1);
    check("t6_rst_flags", 32'({start_o, biz_ack_o, busy_o, session_active_o, error_o}), 0);
    force_done = 1'b1; step(); force_done = 1'b0; withhold = 1'b0;
    step();
    enable_i = 1'b1; step();
    check("t6_relogon", 32'({start_o, message_type_o, msg_seq_num_o}), 32'({1'b1, LOGON, SW'(1)}));

    // Random sessions with random heartbeat intervals, exercising sequence wrap.
    stray = 1'b1;
    for (int s = 0; s < 4; s++) begin
      enable_i = 1'b0; biz_req_i = 1'b0;
      for (int k = 0; k < 100 && (session_active_o === 1'b1 || busy_o === 1'b1); k++) step();
      repeat (3) step();
      hb_interval_i = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(3, 30));
      enable_i = 1'b1;
      repeat (300) begin
        if ($urandom_range(0, 7) == 0) biz_req_i = ~biz_req_i;
        if ($urandom_range(0, 99) == 0) enable_i = ~enable_i;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
